// File: rtl/gpio_pin_ctrl.sv
// Pad-side GPIO stage: registered output/enable, input synchronizer and debouncer,
// and sticky per-pin edge flags that combine into a single interrupt line.
module gpio_pin_ctrl #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rf_gpio_datareg,
    input  logic [WIDTH-1:0] rf_gpio_tristate,
    input  logic [WIDTH-1:0] rf_gpio_interrupt_mask,
    input  logic [WIDTH-1:0] irq_clear,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic [WIDTH-1:0] ro_gpio_pinstate,
    output logic [WIDTH-1:0] irq_pending,
    output logic             irq
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [7:0]       cnt_q  [WIDTH];
    logic [7:0]       cnt_d  [WIDTH];
    logic [WIDTH-1:0] pinstate_q, pinstate_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] pin_out_q, pin_oe_q;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] edge_set;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A bit only updates after s has disagreed with pinstate for DEBOUNCE_CYCLES
    // consecutive edges; the update edge itself is the one that may set pending.
    always_comb begin
        pinstate_d = pinstate_q;
        edge_set   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_s[i] == pinstate_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                pinstate_d[i] = sync_s[i];
                cnt_d[i]      = '0;
                edge_set[i]   = rf_gpio_tristate[i] & rf_gpio_interrupt_mask[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // Set beats clear when both land on the same edge.
    assign pending_d = (pending_q & ~irq_clear) | edge_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            pinstate_q <= '0;
            pending_q  <= '0;
            pin_out_q  <= '0;
            pin_oe_q   <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pinstate_q <= pinstate_d;
            pending_q  <= pending_d;
            pin_out_q  <= rf_gpio_datareg;
            pin_oe_q   <= ~rf_gpio_tristate;
        end
    end

    assign pin_out          = pin_out_q;
    assign pin_oe           = pin_oe_q;
    assign ro_gpio_pinstate = pinstate_q;
    assign irq_pending      = pending_q;
    assign irq              = |(pending_q & rf_gpio_interrupt_mask);

endmodule
